// File: rtl/fifo_rr_read_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO read scheduler.
package fifo_rr_read_scheduler_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int id_bits(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_rr_read_scheduler_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping.
module rr_priority_pick #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        req_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic                found_o,
    output logic [IDX_BITS-1:0] idx_o
);

    logic [IDX_BITS-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_BITS'((32'(ptr_i) + i) % N);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_read_scheduler.sv
// Drains N_CH first-word-fall-through FIFOs round-robin into one registered
// valid/ready stream, in bursts of at most BURST_MAX words tagged by channel.
module fifo_rr_read_scheduler
    import fifo_rr_read_scheduler_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int WIDTH     = 16,
    parameter  int BURST_MAX = 8,
    localparam int CH_BITS   = id_bits(N_CH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [N_CH*WIDTH-1:0] CH_DOUT,
    input  logic [N_CH-1:0]       CH_EMPTY,
    input  logic [N_CH-1:0]       CH_AEMPTY,
    output logic [N_CH-1:0]       CH_RE,
    output logic [WIDTH-1:0]      M_TDATA,
    output logic [CH_BITS-1:0]    M_TUSER,
    output logic                  M_TLAST,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic                  BUSY
);

    localparam int CNT_BITS = id_bits(BURST_MAX);

    state_e               state_q;
    logic [CH_BITS-1:0]   rr_ptr_q;
    logic [CH_BITS-1:0]   rr_ptr_d;
    logic [CH_BITS-1:0]   grant_q;
    logic [CNT_BITS-1:0]  count_q;
    logic [WIDTH-1:0]     tdata_q;
    logic [CH_BITS-1:0]   tuser_q;
    logic                 tlast_q;
    logic                 tvalid_q;

    logic [WIDTH-1:0]     dout_a [N_CH];
    logic [WIDTH-1:0]     g_dout;
    logic                 g_empty;
    logic                 g_aempty;
    logic                 slot_free;
    logic                 pop;
    logic                 last;
    logic                 pick_found;
    logic [CH_BITS-1:0]   pick_idx;

    rr_priority_pick #(
        .N        (N_CH),
        .IDX_BITS (CH_BITS)
    ) u_pick (
        .req_i   (~CH_EMPTY),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            dout_a[k] = CH_DOUT[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        g_dout    = dout_a[grant_q];
        g_empty   = CH_EMPTY[grant_q];
        g_aempty  = CH_AEMPTY[grant_q];
        slot_free = !tvalid_q || M_TREADY;
        pop       = RESET && (state_q == BURST) && slot_free && !g_empty;
        last      = pop && ((count_q == CNT_BITS'(BURST_MAX - 1)) || g_aempty);
        rr_ptr_d  = (32'(grant_q) == N_CH - 1) ? '0 : grant_q + 1'b1;
        CH_RE     = '0;
        if (pop) begin
            CH_RE[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            // A pop below overrides this release of the output slot.
            if (tvalid_q && M_TREADY) begin
                tvalid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (ENABLE && pick_found) begin
                        grant_q <= pick_idx;
                        count_q <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        tdata_q  <= g_dout;
                        tuser_q  <= grant_q;
                        tlast_q  <= last;
                        tvalid_q <= 1'b1;
                        count_q  <= last ? '0 : count_q + 1'b1;
                        if (last) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else if (g_empty) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
            endcase
        end
    end

    assign M_TDATA  = tdata_q;
    assign M_TUSER  = tuser_q;
    assign M_TLAST  = tlast_q;
    assign M_TVALID = tvalid_q;
    assign BUSY     = (state_q != IDLE) || tvalid_q;

endmodule

// File: doc/fifo_rr_read_scheduler.md
Name: fifo_rr_read_scheduler

Overview:
- Round-robin read scheduler that drains N_CH channel FIFOs into one streaming output.
- Each channel FIFO is first-word-fall-through: DOUT always shows the head word, and RE pops at the clock edge when not empty.
- The block grants one channel at a time and reads a burst of at most BURST_MAX words into a registered output stage with valid/ready handshake.
- Each word is tagged with its channel ID; TLAST marks the end of each burst. It sits between the per-channel FIFOs and the readout packetiser.

Parameters:
- N_CH, 4, number of channel FIFOs (2..16).
- WIDTH, 16, data word width.
- BURST_MAX, 8, maximum words read from one channel per grant (1..256).
- CH_BITS, derived = clog2(N_CH) (minimum 1), width of the channel ID.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset: RESET, synchronous, active-low; clock CLK.
- ENABLE  in  1  1 = arbitration allowed; 0 = finish the current burst, then idle.
- CH_DOUT  in  N_CH*WIDTH  head word of each FIFO; channel k occupies [k*WIDTH +: WIDTH].
- CH_EMPTY  in  N_CH  FIFO empty flags.
- CH_AEMPTY  in  N_CH  FIFO almost-empty flags (exactly one word held).
- CH_RE  out  N_CH  pop strobes, combinational, one-hot or zero.
- M_TDATA  out  WIDTH  output word.
- M_TUSER  out  CH_BITS  source channel of M_TDATA.
- M_TLAST  out  1  last word of the current burst.
- M_TVALID  out  1  output register holds a word.
- M_TREADY  in  1  downstream accepts the word.
- BUSY  out  1  FSM not in IDLE, or M_TVALID=1.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - state=IDLE, rr_ptr=0, burst count=0.
  - M_TVALID=0, M_TDATA=0, M_TUSER=0, M_TLAST=0.
  - CH_RE=0 combinationally while RESET=0.
  - A reset mid-burst abandons the burst. Words already popped but not yet accepted are discarded. No flush or replay.
- Output stage:
  - "slot_free" = !M_TVALID | M_TREADY.
  - A word is transferred downstream when M_TVALID & M_TREADY.
  - M_TVALID holds with stable data until it is accepted.
- IDLE:
  - If ENABLE=1 and any CH_EMPTY bit is 0, pick the first non-empty channel searching rr_ptr, rr_ptr+1, ... (mod N_CH).
  - Register the pick as grant g, clear the burst count, and go to BURST.
  - No pop happens in IDLE, so the arbitration gap is 1 cycle.
- BURST:
  - pop = slot_free & !CH_EMPTY[g].
  - CH_RE[g] = pop. On pop, M_TDATA<=CH_DOUT[g], M_TUSER<=g, M_TVALID<=1, count++.
  - last = pop & (count==BURST_MAX-1 | CH_AEMPTY[g]). M_TLAST<=last on each pop.
  - On last: state<=IDLE, rr_ptr<=(g+1) mod N_CH.
  - If CH_EMPTY[g]=1 with no pop (defensive case): go to IDLE, rr_ptr<=g+1. No TLAST is emitted; the previous word keeps its flag.
  - If the slot is not free, hold the state and count; CH_RE=0.
- Latency: from the FIFO going non-empty with the scheduler in IDLE, the pop occurs 1 cycle later and M_TVALID rises 2 cycles later.
- Throughput: 1 word/cycle within a burst while M_TREADY=1.
- ENABLE=0 mid-burst: the burst completes normally, then the FSM stays in IDLE.
- A write to channel g in the same cycle as the pop of its AEMPTY word still ends the burst. The new word is served on a later grant.
- Wrap: rr_ptr wraps from N_CH-1 to 0. The count never exceeds BURST_MAX-1.
- Only granted channel g may ever see CH_RE high, and never while CH_EMPTY[g]=1.

Decomposition:
- Shared package: clog2 function; FSM state encoding (IDLE=0, BURST=1); CH_BITS derivation.
- One sub-module: rr_priority_pick (N_CH-bit request vector + rr_ptr -> found flag + index), purely combinational. It is reusable by other arbiters.

Test Plan:
- Single channel, N_CH=4, BURST_MAX=8, ch2 holds 3 words A,B,C, TREADY=1 -> CH_RE[2] high 3 cycles; out A,B,C with TUSER=2; TLAST on C; rr_ptr=3; BUSY drops.
- All 4 channels hold 20 words each, TREADY=1 -> bursts in order ch0,1,2,3,0,... of 8 words, then 8, then 4; TLAST every 8th word and on each channel's 20th word; 1-cycle gap between bursts.
- Backpressure: ch1 holds 5 words, TREADY toggles 1,0,0,1,... -> no CH_RE while the slot is held; M_TDATA stable while TVALID & !TREADY; all 5 words delivered in order, none lost.
- ENABLE deasserted after the 2nd pop of an 8-word burst on ch0 (10 words held) -> 8 words delivered with TLAST on the 8th; no new grant while ENABLE=0; on re-enable ch0 resumes with the remaining 2 words.
- RESET low mid-burst (ch3, 3 of 8 words popped) -> next cycle TVALID=0 and CH_RE=0; after release arbitration restarts from ch0.
- Fairness: ch0 is continuously refilled and ch2 holds 1 word -> ch2 is granted right after ch0's first 8-word burst; its word carries TLAST via AEMPTY.
